// File: rtl/mem_arbiter_pkg.sv
// Shared types for the two-port memory arbiter: word/mask types, FSM states
// and the packed command payload latched on a grant.
package mem_arbiter_pkg;

  localparam int unsigned ARB_WORD_W               = 16;
  localparam int unsigned ARB_MASK_W               = 2;
  localparam int unsigned ARB_MAX_B_STREAK_DEFAULT = 2;

  typedef logic [ARB_WORD_W-1:0] lc3b_word;
  typedef logic [ARB_MASK_W-1:0] lc3b_mem_wmask;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY_A,
    ARB_BUSY_B
  } arb_state_t;

  typedef struct packed {
    logic          read;
    logic          write;
    lc3b_mem_wmask wmask;
    lc3b_word      address;
    lc3b_word      wdata;
  } arb_cmd_t;

  // A simultaneous read+write is treated as a write.
  function automatic arb_cmd_t arb_make_cmd(input logic          rd,
                                            input logic          wr,
                                            input lc3b_mem_wmask mask,
                                            input lc3b_word      addr,
                                            input lc3b_word      data);
    arb_cmd_t cmd;
    cmd.read    = rd & ~wr;
    cmd.write   = wr;
    cmd.wmask   = mask;
    cmd.address = addr;
    cmd.wdata   = data;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arb_hold.sv
// Holding register for the granted memory command; loaded on a grant and
// kept stable until the transaction completes.
module mem_arb_hold
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     reset_n,
  input  logic     load_i,
  input  arb_cmd_t cmd_i,
  output arb_cmd_t cmd_o
);

  arb_cmd_t cmd_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_q <= '0;
    end else if (load_i) begin
      cmd_q <= cmd_i;
    end
  end

  assign cmd_o = cmd_q;

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: data port (B) has priority, fetch (A) is forced
// in after MAX_B_STREAK contested B grants. MEM_ARBITER_PERF_CNT_EN enables the conflict counter.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned MAX_B_STREAK = ARB_MAX_B_STREAK_DEFAULT,
  parameter int unsigned ADDR_W       = ARB_WORD_W
) (
  input  logic              clk,
  input  logic              reset_n,

  input  logic              a_read,
  input  logic              a_write,
  input  logic [1:0]        a_wmask,
  input  logic [ADDR_W-1:0] a_address,
  input  logic [ADDR_W-1:0] a_wdata,
  output logic [ADDR_W-1:0] a_rdata,
  output logic              a_resp,

  input  logic              b_read,
  input  logic              b_write,
  input  logic [1:0]        b_wmask,
  input  logic [ADDR_W-1:0] b_address,
  input  logic [ADDR_W-1:0] b_wdata,
  output logic [ADDR_W-1:0] b_rdata,
  output logic              b_resp,

  output logic              mem_read,
  output logic              mem_write,
  output logic [1:0]        mem_wmask,
  output logic [ADDR_W-1:0] mem_address,
  output logic [ADDR_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] mem_rdata,
  input  logic              mem_resp,

  output logic [15:0]       perf_conflict_cnt
);

  localparam int unsigned STREAK_W = $clog2(MAX_B_STREAK + 1);

  arb_state_t          state_q, state_d;
  logic [STREAK_W-1:0] b_streak_q, b_streak_d;
  logic                req_a, req_b, busy;
  logic                load, grant_b;
  arb_cmd_t            cmd_a, cmd_b, win_cmd, hold_cmd;

  assign req_a = a_read | a_write;
  assign req_b = b_read | b_write;

  assign cmd_a = arb_make_cmd(a_read, a_write, a_wmask,
                              ARB_WORD_W'(a_address), ARB_WORD_W'(a_wdata));
  assign cmd_b = arb_make_cmd(b_read, b_write, b_wmask,
                              ARB_WORD_W'(b_address), ARB_WORD_W'(b_wdata));
  assign win_cmd = grant_b ? cmd_b : cmd_a;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ARB_IDLE;
      b_streak_q <= '0;
    end else begin
      state_q    <= state_d;
      b_streak_q <= b_streak_d;
    end
  end

  // Grant selection in IDLE; completion on mem_resp in either BUSY state.
  always_comb begin
    state_d    = state_q;
    b_streak_d = b_streak_q;
    load       = 1'b0;
    grant_b    = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (req_b && (!req_a || (b_streak_q < STREAK_W'(MAX_B_STREAK)))) begin
          grant_b    = 1'b1;
          load       = 1'b1;
          state_d    = ARB_BUSY_B;
          b_streak_d = req_a ? STREAK_W'(b_streak_q + STREAK_W'(1)) : '0;
        end else if (req_a) begin
          load       = 1'b1;
          state_d    = ARB_BUSY_A;
          b_streak_d = '0;
        end
      end
      ARB_BUSY_A, ARB_BUSY_B: begin
        if (mem_resp) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  mem_arb_hold u_hold (
    .clk     (clk),
    .reset_n (reset_n),
    .load_i  (load),
    .cmd_i   (win_cmd),
    .cmd_o   (hold_cmd)
  );

  // Memory side sees only the latched command, and nothing while idle.
  assign busy        = (state_q != ARB_IDLE);
  assign mem_read    = busy & hold_cmd.read;
  assign mem_write   = busy & hold_cmd.write;
  assign mem_wmask   = busy ? hold_cmd.wmask : '0;
  assign mem_address = busy ? ADDR_W'(hold_cmd.address) : '0;
  assign mem_wdata   = busy ? ADDR_W'(hold_cmd.wdata) : '0;

  assign a_resp  = (state_q == ARB_BUSY_A) & mem_resp;
  assign b_resp  = (state_q == ARB_BUSY_B) & mem_resp;
  assign a_rdata = a_resp ? mem_rdata : '0;
  assign b_rdata = b_resp ? mem_rdata : '0;

`ifdef MEM_ARBITER_PERF_CNT_EN
  logic [15:0] perf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_q <= '0;
    end else if (req_a && req_b && (perf_q != 16'hFFFF)) begin
      perf_q <= perf_q + 16'd1;
    end
  end

  assign perf_conflict_cnt = perf_q;
`else
  assign perf_conflict_cnt = 16'h0000;
`endif

`ifndef SYNTHESIS
  logic win_rw_both;
  assign win_rw_both = grant_b ? (b_read & b_write) : (a_read & a_write);

  always @(posedge clk) begin
    if (reset_n && load) begin
      assert (!win_rw_both)
        else $warning("mem_arbiter: read and write both asserted on grant, treated as write");
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int MAXS = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_read, a_write, b_read, b_write;
  logic [1:0]  a_wmask, b_wmask;
  logic [15:0] a_address, a_wdata, b_address, b_wdata;
  logic [15:0] a_rdata, b_rdata;
  logic        a_resp, b_resp;
  logic        mem_read, mem_write, mem_resp;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address, mem_wdata, mem_rdata;
  logic [15:0] perf_conflict_cnt;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .a_read            (a_read),
    .a_write           (a_write),
    .a_wmask           (a_wmask),
    .a_address         (a_address),
    .a_wdata           (a_wdata),
    .a_rdata           (a_rdata),
    .a_resp            (a_resp),
    .b_read            (b_read),
    .b_write           (b_write),
    .b_wmask           (b_wmask),
    .b_address         (b_address),
    .b_wdata           (b_wdata),
    .b_rdata           (b_rdata),
    .b_resp            (b_resp),
    .mem_read          (mem_read),
    .mem_write         (mem_write),
    .mem_wmask         (mem_wmask),
    .mem_address       (mem_address),
    .mem_wdata         (mem_wdata),
    .mem_rdata         (mem_rdata),
    .mem_resp          (mem_resp),
    .perf_conflict_cnt (perf_conflict_cnt)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // Reference model: who owns the memory (0 none, 1 A, 2 B), the command it
  // was granted with, the contested-B counter and the conflict counter.
  int          m_owner, m_streak, m_perf;
  logic        m_rd, m_wr;
  logic [1:0]  m_mask;
  logic [15:0] m_addr, m_wd;
  logic        e_ar, e_br;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner  = 0;
    m_streak = 0;
    m_perf   = 0;
    m_rd     = 1'b0;
    m_wr     = 1'b0;
    m_mask   = 2'b00;
    m_addr   = 16'h0;
    m_wd     = 16'h0;
  endtask

  task automatic settle();
    logic        busy;
    logic [15:0] ep;
    #1;
    busy = (m_owner != 0);
    e_ar = (m_owner == 1) && mem_resp;
    e_br = (m_owner == 2) && mem_resp;
`ifdef MEM_ARBITER_PERF_CNT_EN
    ep = 16'(m_perf);
`else
    ep = 16'h0000;
`endif
    chk("mem_read",    32'(mem_read),    32'(busy && m_rd));
    chk("mem_write",   32'(mem_write),   32'(busy && m_wr));
    chk("mem_wmask",   32'(mem_wmask),   32'(busy ? m_mask : 2'b00));
    chk("mem_address", 32'(mem_address), 32'(busy ? m_addr : 16'h0));
    chk("mem_wdata",   32'(mem_wdata),   32'(busy ? m_wd : 16'h0));
    chk("a_resp",      32'(a_resp),      32'(e_ar));
    chk("b_resp",      32'(b_resp),      32'(e_br));
    chk("a_rdata",     32'(a_rdata),     32'(e_ar ? mem_rdata : 16'h0));
    chk("b_rdata",     32'(b_rdata),     32'(e_br ? mem_rdata : 16'h0));
    chk("perf_cnt",    32'(perf_conflict_cnt), 32'(ep));
  endtask

  task automatic adv();
    logic ra, rb;
    int   win;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      ra = a_read | a_write;
      rb = b_read | b_write;
      if (ra && rb && m_perf < 65535) m_perf++;
      if (m_owner == 0) begin
        win = 0;
        if (ra && rb)  win = (m_streak >= MAXS) ? 1 : 2;
        else if (ra)   win = 1;
        else if (rb)   win = 2;
        if (win == 1) begin
          m_streak = 0;
          m_rd = a_read && !a_write; m_wr = a_write;
          m_mask = a_wmask; m_addr = a_address; m_wd = a_wdata;
        end else if (win == 2) begin
          m_streak = ra ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
          m_rd = b_read && !b_write; m_wr = b_write;
          m_mask = b_wmask; m_addr = b_address; m_wd = b_wdata;
        end
        m_owner = win;
      end else if (mem_resp) begin
        m_owner = 0;
      end
    end
    @(negedge clk);
  endtask

  int got[$];
  int exp_order[6] = '{2, 2, 1, 2, 2, 1};
  logic a_pend, b_pend;

  initial begin
    reset_n = 1'b0;
    a_read = 0; a_write = 0; a_wmask = 0; a_address = 0; a_wdata = 0;
    b_read = 0; b_write = 0; b_wmask = 0; b_address = 0; b_wdata = 0;
    mem_resp = 0; mem_rdata = 0;
    model_reset();
    @(negedge clk);

    // Reset state
    settle(); adv();
    reset_n = 1'b1;
    settle(); adv();

    // A only: grant, three-cycle memory latency
    a_read = 1'b1; a_address = 16'h0040;
    settle(); adv();
    settle(); chk("aonly_c1_read", 32'(mem_read), 32'd1);
    chk("aonly_c1_addr", 32'(mem_address), 32'h0040); adv();
    settle(); adv();
    mem_resp = 1'b1; mem_rdata = 16'h1234;
    settle(); chk("aonly_c3_resp", 32'(a_resp), 32'd1);
    chk("aonly_c3_rdata", 32'(a_rdata), 32'h1234);
    chk("aonly_c3_bresp", 32'(b_resp), 32'd0); adv();
    a_read = 1'b0; mem_resp = 1'b0;
    settle(); adv();

    // Simultaneous A read / B write; B wins, command held while busy
    a_read = 1'b1; a_address = 16'h0100;
    b_write = 1'b1; b_address = 16'h2000; b_wdata = 16'hBEEF; b_wmask = 2'b01;
    settle(); adv();
    settle(); chk("sim_b_write", 32'(mem_write), 32'd1);
    chk("sim_b_wdata", 32'(mem_wdata), 32'hBEEF);
    chk("sim_b_wmask", 32'(mem_wmask), 32'h1); adv();
    b_address = 16'h3000;
    settle(); chk("held_addr", 32'(mem_address), 32'h2000); adv();
    mem_resp = 1'b1; mem_rdata = 16'h5555;
    settle(); chk("sim_b_resp", 32'(b_resp), 32'd1);
    chk("sim_a_wait", 32'(a_resp), 32'd0); adv();
    mem_resp = 1'b0; b_write = 1'b0;
    settle(); chk("gap_idle", 32'(mem_read | mem_write), 32'd0); adv();
    settle(); chk("sim_a_read", 32'(mem_read), 32'd1);
    chk("sim_a_addr", 32'(mem_address), 32'h0100); adv();
    mem_resp = 1'b1;
    settle(); chk("sim_a_resp", 32'(a_resp), 32'd1); adv();
    a_read = 1'b0; mem_resp = 1'b0;
    settle(); adv();

    // Starvation guard: both request continuously
    got.delete();
    a_read = 1'b1; a_address = 16'h0A00;
    b_read = 1'b1; b_address = 16'h0B00;
    for (int c = 0; c < 40 && got.size() < 6; c++) begin
      mem_resp = (m_owner != 0); mem_rdata = 16'(c);
      settle();
      if (a_resp) got.push_back(1);
      if (b_resp) got.push_back(2);
      adv();
    end
    a_read = 1'b0; b_read = 1'b0; mem_resp = 1'b0;
    for (int i = 0; i < 6; i++)
      chk($sformatf("starve_order%0d", i), 32'(i < got.size() ? got[i] : 0), 32'(exp_order[i]));
    settle(); adv();

    // Reset in BUSY_A, then a stray mem_resp after release
    a_read = 1'b1; a_address = 16'h0C00;
    settle(); adv();
    settle();
    reset_n = 1'b0; a_read = 1'b0; model_reset();
    settle(); chk("rst_mid_read", 32'(mem_read), 32'd0); adv();
    reset_n = 1'b1; mem_resp = 1'b1; mem_rdata = 16'hDEAD;
    settle(); chk("rst_stray_aresp", 32'(a_resp), 32'd0);
    chk("rst_stray_ardata", 32'(a_rdata), 32'd0); adv();
    mem_resp = 1'b0;
    settle(); adv();

    // Conflict counter: five cycles of dual requests from a fresh reset
    reset_n = 1'b0; model_reset();
    settle(); adv();
    reset_n = 1'b1;
    a_read = 1'b1; b_read = 1'b1;
    for (int i = 0; i < 5; i++) begin settle(); adv(); end
    a_read = 1'b0; b_read = 1'b0;
    settle();
`ifdef MEM_ARBITER_PERF_CNT_EN
    chk("perf_five", 32'(perf_conflict_cnt), 32'd5);
`else
    chk("perf_off", 32'(perf_conflict_cnt), 32'd0);
`endif
    adv();
    reset_n = 1'b0; model_reset();
    settle(); adv();
    reset_n = 1'b1;

    // Random traffic: requesters hold until served, memory responds randomly
    a_pend = 1'b0; b_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!a_pend && $urandom_range(0, 2) == 0) begin
        a_pend = 1'b1;
        a_write = ($urandom_range(0, 3) == 0); a_read = ~a_write;
        a_address = 16'($urandom); a_wdata = 16'($urandom); a_wmask = 2'($urandom);
      end else if (a_pend && $urandom_range(0, 9) == 0) begin
        a_address = 16'($urandom);
      end
      if (!b_pend && $urandom_range(0, 1) == 0) begin
        b_pend = 1'b1;
        b_write = ($urandom_range(0, 1) == 0); b_read = ~b_write;
        b_address = 16'($urandom); b_wdata = 16'($urandom); b_wmask = 2'($urandom);
      end else if (b_pend && $urandom_range(0, 9) == 0) begin
        b_wdata = 16'($urandom);
      end
      mem_resp = ($urandom_range(0, 2) == 0); mem_rdata = 16'($urandom);
      settle();
      adv();
      if (e_ar) begin a_pend = 1'b0; a_read = 1'b0; a_write = 1'b0; end
      if (e_br) begin b_pend = 1'b0; b_read = 1'b0; b_write = 1'b0; end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one physical memory port between two requesters: instruction fetch (port A) and the memory-stage data port (port B, driven by mem_datapath).
- Sits between the pipeline and the cache/physical memory.
- Data port has fixed priority, with an anti-starvation guard for fetch.
- Commands are latched and held until the memory responds.

Parameters:
- MAX_B_STREAK, 2: consecutive B grants allowed while A is waiting before A is forced in.
- ADDR_W, 16: address/data width (lc3b_word).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- a_read  in  1  fetch read request
- a_write  in  1  fetch write request (normally 0)
- a_wmask  in  2  fetch byte mask
- a_address  in  16  fetch address
- a_wdata  in  16  fetch write data
- a_rdata  out  16  read data to fetch
- a_resp  out  1  fetch transaction complete
- b_read, b_write, b_wmask, b_address, b_wdata, b_rdata, b_resp: same shapes for the data port
- mem_read  out  1  to memory
- mem_write  out  1  to memory
- mem_wmask  out  2  to memory
- mem_address  out  16  to memory
- mem_wdata  out  16  to memory
- mem_rdata  in  16  from memory
- mem_resp  in  1  from memory, one-cycle completion pulse
- perf_conflict_cnt  out  16  see Optional Feature

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset state:
  - state=IDLE, b_streak=0, holding regs=0.
  - All outputs 0: mem_read, mem_write, mem_wmask, mem_address, mem_wdata, a_resp, b_resp, a_rdata, b_rdata.
- States: IDLE, BUSY_A, BUSY_B.
- IDLE, request sampling:
  - req_x = x_read | x_write.
  - Both pending: grant B unless b_streak >= MAX_B_STREAK, then grant A.
  - One pending: grant it.
  - None pending: stay IDLE.
- Grant latching: on the grant edge, latch read/write/wmask/address/wdata of the winner into holding regs and move to BUSY_x.
- BUSY_x:
  - mem_* driven from the holding regs only. Requester-side changes are ignored until completion.
  - On mem_resp=1:
    - x_resp=1 combinationally in the same cycle.
    - x_rdata = mem_rdata in that cycle; 0 otherwise.
    - Next state is IDLE.
- Latency:
  - Request at cycle 0 → mem_read/mem_write asserted at cycle 1.
  - x_resp is coincident with mem_resp.
  - Back-to-back transactions always have one IDLE cycle between them.
- Read and write both asserted by a requester: latched as a write with read cleared. A simulation assertion flags it.
- mem_resp while IDLE: ignored, no x_resp.
- b_streak:
  - +1 on each B grant made while req_a=1 (saturates at MAX_B_STREAK).
  - Cleared on any A grant.
  - Cleared on a B grant with req_a=0.
- Non-granted requester: its resp stays 0. It holds its request (the pipeline stalls on ~resp).
- Reset mid-transaction:
  - Immediate return to IDLE with outputs at reset values.
  - The in-flight memory response is dropped.
  - The memory side must tolerate abandonment.
- Wmask: passed unmodified. Byte-lane selection for STB is upstream.

Optional Feature:
- Macro: MEM_ARBITER_PERF_CNT_EN.
- Defined:
  - perf_conflict_cnt increments (saturating at 16'hFFFF) every cycle where req_a & req_b are both high, in any state.
  - Reset to 0.
- Undefined: perf_conflict_cnt tied to 16'h0000; no counter flops.

Decomposition:
- lc3b_types additions:
  - enum arb_state_t {ARB_IDLE, ARB_BUSY_A, ARB_BUSY_B}.
  - localparam-style constant ARB_MAX_B_STREAK_DEFAULT=2.
  - Reuse lc3b_word and lc3b_mem_wmask.
- Sub-module mem_arb_hold: latches {read, write, wmask, address, wdata} on load; async active-low clear. Instantiated once and fed by the winner mux.

Test Plan:
- A only: a_read=1, a_address=16'h0040; mem_resp at cycle 3 with mem_rdata=16'h1234 → mem_read=1 with address 16'h0040 from cycle 1; a_resp=1 and a_rdata=16'h1234 at cycle 3; b_resp=0 throughout.
- Simultaneous: a_read and b_write (b_address=16'h2000, b_wdata=16'hBEEF, b_wmask=2'b01) at cycle 0 → B served first with mem_write=1, mem_wdata=16'hBEEF, mem_wmask=2'b01; A granted after the IDLE cycle following b_resp.
- Starvation guard: B requests continuously while A is held, MAX_B_STREAK=2 → grants in order B, B, A, B, B, A.
- Held command: change b_address from 16'h2000 to 16'h3000 during BUSY_B → mem_address stays 16'h2000 until mem_resp.
- Reset mid-op: reset_n low in BUSY_A, then mem_resp=1 after release with no request pending → all outputs 0, a_resp never asserted, state IDLE.
- With MEM_ARBITER_PERF_CNT_EN: 5 cycles of dual requests → perf_conflict_cnt=5. Without the macro → 0.
